fifo_gen2: RTL and testbench
============================

# fifo_gen2

Second-generation synchronous FIFO: single clock, parametrised width/depth, selectable standard or first-word-fall-through (FWFT) read mode. Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush and correct simultaneous read/write accounting. Drop-in buffer between any two same-clock producer/consumer stages in the datapath.

## Interface
- DEPTH, 8, number of entries; any integer ≥ 2 (power of two not required)
- WIDTH, 8, data width in bits
- FWFT, 0, 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of contents, pointers and error flags
- write  in  1  push request
- read  in  1  pop request
- din  in  WIDTH  write data
- dout  out  WIDTH  read data
- dout_valid  out  1  dout carries a valid popped/head word
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- status_counter  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read hit an empty FIFO

## Operation
- Storage: DEPTH×WIDTH register array; wr_ptr/rd_ptr of max(1,$clog2(DEPTH)) bits; each wraps DEPTH-1 → 0 explicitly (not by overflow).
- Priority per edge: rst > flush > read/write.
- Read accepted (rd_acc) = read && !fifo_empty.
- Write accepted (wr_acc) = write && (!fifo_full || rd_acc); full + simultaneous pop = pass-through, not overflow.
- Count update: +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither.
- On empty FIFO with read && write: write accepted, read rejected, underflow set.
- overflow set when write && !wr_acc; underflow set when read && fifo_empty. Both hold until rst or flush.
- Flags (full, empty, almost_*) are combinational decodes of registered status_counter.
- Standard mode (FWFT=0): on rd_acc, dout <= mem[rd_ptr] and dout_valid <= 1 next edge; otherwise dout_valid <= 0, dout holds last value.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] when !fifo_empty, else 0; dout_valid = !fifo_empty; read acts as acknowledge/pop of the displayed word.
- flush: wr_ptr, rd_ptr, status_counter, overflow, underflow, dout_valid → 0; dout → 0; concurrent read/write ignored, no error flagged. Memory contents not cleared.

## Timing
- Reset values: dout 0, dout_valid 0, status_counter 0, fifo_empty 1, fifo_full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.
- rst asserted mid-operation: all state above restored on that edge; in-flight read/write in the same cycle discarded.
- Write-to-count: status_counter and flags reflect a write one cycle after the accepting edge.
- Standard read latency: read sampled at edge N → dout/dout_valid valid after edge N, for one cycle.
- FWFT: word written at edge N into empty FIFO visible on dout with dout_valid after edge N (write-to-output 1 cycle).
- Back-to-back read+write every cycle at any fill level 1..DEPTH-1 sustains full throughput with constant count.
- Pointer wrap at DEPTH-1 → 0 has no bubble.

## Test plan
- Reset/fill/drain, DEPTH=8, FWFT=0: write 0x01..0x08 → fifo_full=1, count=8, almost_full=1 from count 7; 8 reads → dout 0x01..0x08 in order, one cycle after each read, fifo_empty=1.
- Overflow/pass-through: full FIFO, write 0xAA alone → overflow=1, count=8, 0xAA never read; full FIFO, read+write 0xBB together → overflow stays 0, count=8, 0xBB emerges 8th.
- Underflow: empty FIFO, read → underflow=1, dout_valid=0; read+write 0x55 on empty → count=1, underflow=1; flush → underflow=0, count=0.
- Wrap with DEPTH=5 (non-power-of-2): 12 writes interleaved with reads keeping count 2..4 → output sequence identical to input, no loss or duplication.
- FWFT=1: write 0x3C to empty → next cycle dout=0x3C, dout_valid=1 with no read; read → dout_valid=0, dout=0 when empty.
- Synchronous reset mid-stream: count=5, assert rst with read+write high → next cycle count=0, empty=1, dout=0, dout_valid=0, flags cleared.

Source files
------------

// File: rtl/fifo_gen2.sv
// fifo_gen2 -- single-clock synchronous FIFO with standard or
// first-word-fall-through read mode.
//
// Parameters:
//   DEPTH     number of entries (>= 2, any integer)
//   WIDTH     data width
//   FWFT      0 = registered read (1-cycle latency), 1 = head word shown on dout
//   AF_LEVEL  almost_full when status_counter >= AF_LEVEL
//   AE_LEVEL  almost_empty when status_counter <= AE_LEVEL
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   flush            synchronous clear of pointers, count, dout and error flags
//   write, din       push request and data
//   read             pop request (acknowledge of the head word in FWFT mode)
//   dout, dout_valid read data and its qualifier
//   fifo_full/empty, almost_full/empty   decodes of status_counter
//   status_counter   occupancy 0..DEPTH
//   overflow         sticky: a write was dropped
//   underflow        sticky: a read found the FIFO empty
module fifo_gen2 #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter bit FWFT     = 1'b0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       write,
  input  logic                       read,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] status_counter,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             rd_acc;
  logic             wr_acc;
  logic             clr;

  assign clr            = rst | flush;
  assign status_counter = count;
  assign fifo_full      = (count == FULL_C);
  assign fifo_empty     = (count == '0);
  assign almost_full    = (count >= AF_C);
  assign almost_empty   = (count <= AE_C);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a
  // simultaneous push (pass-through).
  assign rd_acc = read & ~fifo_empty;
  assign wr_acc = write & (~fifo_full | rd_acc);

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (write && !wr_acc)   overflow  <= 1'b1;
      if (read && fifo_empty) underflow <= 1'b1;
    end
  end

  // Storage is data only: never cleared, just not written during rst/flush.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem[wr_ptr] <= din;
  end

  if (FWFT == 1'b0) begin : g_std
    logic [WIDTH-1:0] dout_p1;
    logic             vld_p1;

    // ---- read stage: registered pop result, valid for one cycle ----
    always_ff @(posedge clk) begin
      if (clr) begin
        dout_p1 <= '0;
        vld_p1  <= 1'b0;
      end else if (rd_acc) begin
        dout_p1 <= mem[rd_ptr];
        vld_p1  <= 1'b1;
      end else begin
        vld_p1  <= 1'b0;
      end
    end

    assign dout       = dout_p1;
    assign dout_valid = vld_p1;
  end else begin : g_fwft
    assign dout       = fifo_empty ? '0 : mem[rd_ptr];
    assign dout_valid = ~fifo_empty;
  end

endmodule

// File: tb/tb_fifo_gen2.sv
module tb_fifo_gen2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // A: DEPTH=8, standard read
  logic       flush_a, write_a, read_a;
  logic [7:0] din_a, dout_a;
  logic       dv_a, full_a, empty_a, af_a, ae_a, ov_a, un_a;
  logic [3:0] cnt_a;

  // B: DEPTH=5, FWFT
  logic       flush_b, write_b, read_b;
  logic [7:0] din_b, dout_b;
  logic       dv_b, full_b, empty_b, af_b, ae_b, ov_b, un_b;
  logic [2:0] cnt_b;

  fifo_gen2 #(.DEPTH(8), .WIDTH(8), .FWFT(1'b0)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a), .write(write_a), .read(read_a),
    .din(din_a), .dout(dout_a), .dout_valid(dv_a), .fifo_full(full_a),
    .fifo_empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .status_counter(cnt_a), .overflow(ov_a), .underflow(un_a));

  fifo_gen2 #(.DEPTH(5), .WIDTH(8), .FWFT(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b), .write(write_b), .read(read_b),
    .din(din_b), .dout(dout_b), .dout_valid(dv_b), .fifo_full(full_b),
    .fifo_empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .status_counter(cnt_b), .overflow(ov_b), .underflow(un_b));

  // Reference model: queue contents plus sticky flags and last popped word.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       ova, una, dva, ovb, unb;
  logic [7:0] da;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_a();
    bit racc, wacc;
    if (rst || flush_a) begin
      qa.delete(); ova = 0; una = 0; da = 8'h00; dva = 0;
    end else begin
      racc = read_a && (qa.size() != 0);
      wacc = write_a && ((qa.size() != 8) || racc);
      if (read_a && qa.size() == 0) una = 1;
      if (write_a && !wacc) ova = 1;
      if (racc) begin da = qa.pop_front(); dva = 1; end
      else dva = 0;
      if (wacc) qa.push_back(din_a);
    end
  endtask

  task automatic model_b();
    bit racc, wacc;
    if (rst || flush_b) begin
      qb.delete(); ovb = 0; unb = 0;
    end else begin
      racc = read_b && (qb.size() != 0);
      wacc = write_b && ((qb.size() != 5) || racc);
      if (read_b && qb.size() == 0) unb = 1;
      if (write_b && !wacc) ovb = 1;
      if (racc) void'(qb.pop_front());
      if (wacc) qb.push_back(din_b);
    end
  endtask

  function automatic logic [31:0] obs_a();
    return {13'b0, dout_a, dv_a, cnt_a, full_a, empty_a, af_a, ae_a, ov_a, un_a};
  endfunction

  function automatic logic [31:0] exp_a();
    int n = qa.size();
    return {13'b0, da, dva, 4'(n), n == 8, n == 0, n >= 7, n <= 1, ova, una};
  endfunction

  function automatic logic [31:0] obs_b();
    return {14'b0, dout_b, dv_b, cnt_b, full_b, empty_b, af_b, ae_b, ov_b, un_b};
  endfunction

  function automatic logic [31:0] exp_b();
    int n = qb.size();
    logic [7:0] h = (n == 0) ? 8'h00 : qb[0];
    return {14'b0, h, n != 0, 3'(n), n == 5, n == 0, n >= 4, n <= 1, ovb, unb};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_a();
    model_b();
    #1;
    chk("model_a", obs_a(), exp_a());
    chk("model_b", obs_b(), exp_b());
  endtask

  task automatic idle_all();
    flush_a = 0; write_a = 0; read_a = 0; din_a = 8'h00;
    flush_b = 0; write_b = 0; read_b = 0; din_b = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    chk("reset_a", obs_a(), 32'h14);
    chk("reset_b", obs_b(), 32'h14);
    rst = 1'b0;

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      write_a = 1; din_a = 8'(i);
      tick();
      if (i == 7) chk("af_at_7", {31'b0, af_a}, 32'd1);
    end
    write_a = 0;
    chk("full_count", {27'b0, cnt_a, full_a}, {27'b0, 4'd8, 1'b1});

    // Dropped write on full FIFO
    write_a = 1; din_a = 8'hAA;
    tick();
    write_a = 0;
    chk("overflow_set", {28'b0, cnt_a, ov_a} >> 0, {27'b0, 4'd8, 1'b1});

    // Drain: 0x01..0x08 one cycle after each read, 0xAA never appears
    for (int i = 1; i <= 8; i++) begin
      read_a = 1;
      tick();
      chk("drain_order", {24'b0, dout_a}, 32'(i));
    end
    read_a = 0;
    tick();
    chk("drained", {30'b0, empty_a, dv_a}, 32'b10);

    // Pass-through on full FIFO
    flush_a = 1; tick(); flush_a = 0;
    for (int i = 1; i <= 8; i++) begin
      write_a = 1; din_a = 8'(i); tick();
    end
    read_a = 1; write_a = 1; din_a = 8'hBB;
    tick();
    write_a = 0;
    chk("passthru", {27'b0, cnt_a, ov_a}, {27'b0, 4'd8, 1'b0});
    for (int i = 0; i < 8; i++) tick();
    read_a = 0;
    chk("bb_last", {24'b0, dout_a}, 32'hBB);

    // Underflow
    read_a = 1; tick(); read_a = 0;
    chk("underflow", {30'b0, un_a, dv_a}, 32'b10);
    read_a = 1; write_a = 1; din_a = 8'h55; tick();
    read_a = 0; write_a = 0;
    chk("rw_empty", {27'b0, cnt_a, un_a}, {27'b0, 4'd1, 1'b1});
    flush_a = 1; tick(); flush_a = 0;
    chk("flush_clr", {27'b0, cnt_a, un_a}, 32'd0);

    // FWFT: write-to-output in one cycle, read acknowledges
    write_b = 1; din_b = 8'h3C; tick(); write_b = 0;
    chk("fwft_show", {23'b0, dout_b, dv_b}, {23'b0, 8'h3C, 1'b1});
    tick();
    chk("fwft_hold", {23'b0, dout_b, dv_b}, {23'b0, 8'h3C, 1'b1});
    read_b = 1; tick(); read_b = 0;
    chk("fwft_empty", {23'b0, dout_b, dv_b}, 32'd0);

    // DEPTH=5 wrap: keep occupancy in 2..4 while pushing 12 words
    for (int i = 0; i < 2; i++) begin
      write_b = 1; din_b = 8'(8'h80 + i); tick();
    end
    for (int i = 0; i < 12; i++) begin
      write_b = 1; din_b = 8'(8'h10 + i);
      read_b  = (qb.size() >= 3) || ($urandom_range(0, 1) == 1 && qb.size() >= 2);
      tick();
    end
    write_b = 0; read_b = 0;
    chk("wrap_noerr", {30'b0, ov_b, un_b}, 32'd0);

    // Randomized traffic on both instances
    for (int i = 0; i < 500; i++) begin
      write_a = ($urandom_range(0, 99) < 55);
      read_a  = ($urandom_range(0, 99) < 50);
      din_a   = 8'($urandom);
      flush_a = ($urandom_range(0, 59) == 0);
      write_b = ($urandom_range(0, 99) < 50);
      read_b  = ($urandom_range(0, 99) < 55);
      din_b   = 8'($urandom);
      flush_b = ($urandom_range(0, 59) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      tick();
    end
    idle_all();
    rst = 0;

    // Reset mid-stream with read+write pending
    flush_a = 1; tick(); flush_a = 0;
    for (int i = 0; i < 5; i++) begin
      write_a = 1; din_a = 8'(8'h40 + i); tick();
    end
    chk("count5", {28'b0, cnt_a}, 32'd5);
    rst = 1; read_a = 1; write_a = 1; din_a = 8'hEE;
    tick();
    rst = 0; idle_all();
    chk("midreset_a", obs_a(), 32'h14);
    tick();
    chk("after_reset", {27'b0, cnt_a, empty_a}, 32'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
